div8_seq: RTL

Sequential 8-bit unsigned restoring divider that sits directly around the team's 8-bit ripple subtractor. Each cycle it drives the subtractor's `a` and `b` operands with the trial remainder and the divisor. It then consumes the subtractor's difference and carry-out to decide each quotient bit. One division takes 8 iterations behind a start/done handshake. Results are registered and held until the next accepted request.

---
 rtl/div8_pkg.sv | 8 +
 rtl/div8_seq.sv | 105 ++++++++++
 2 files changed

// File: rtl/div8_pkg.sv
// Shared types and sizing for the 8-bit sequential restoring divider.
package div8_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} div8_state_e;

    localparam int DIV8_W     = 8;
    localparam int DIV8_ITER  = 8;
    localparam int DIV8_CNT_W = 4;
endpackage

// File: rtl/div8_seq.sv
// Sequential 8-bit unsigned restoring divider driving an external ripple subtractor.
// Optional divide-by-zero short-cut enabled by defining DIV8_DIVZERO_EN.
module div8_seq
    import div8_pkg::*;
#(
    parameter int WIDTH = DIV8_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    input  logic [WIDTH-1:0] sub_diff,
    input  logic             sub_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz_err
);

    div8_state_e           state, state_nx;
    logic [WIDTH-1:0]      d, q, r;
    logic [WIDTH-1:0]      q_nx, r_nx;
    logic [DIV8_CNT_W-1:0] cnt;
    logic [WIDTH:0]        trial;
    logic                  ok, accept, last, dz_hit;

    // Trial remainder: shift the next dividend bit into R; bit WIDTH forces success.
    assign trial  = {r, q[WIDTH-1]};
    assign sub_a  = trial[WIDTH-1:0];
    assign sub_b  = d;
    assign ok     = trial[WIDTH] | sub_cout;
    assign r_nx   = ok ? sub_diff : trial[WIDTH-1:0];
    assign q_nx   = {q[WIDTH-2:0], ok};

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (cnt == DIV8_CNT_W'(DIV8_ITER - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

`ifdef DIV8_DIVZERO_EN
    logic dz_q;

    assign dz_hit = (divisor == '0);
    assign dz_err = dz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dz_q <= 1'b0;
        end else if (accept) begin
            dz_q <= dz_hit;
        end
    end
`else
    assign dz_hit = 1'b0;
    assign dz_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = dz_hit ? DONE : RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? (dz_hit ? DONE : RUN) : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            d         <= '0;
            q         <= '0;
            r         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                d   <= divisor;
                q   <= dividend;
                r   <= '0;
                cnt <= '0;
                // Zero divisor only reaches here with the short-cut enabled.
                if (dz_hit) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
            end else if (state == RUN) begin
                q   <= q_nx;
                r   <= r_nx;
                cnt <= cnt + 1'b1;
                if (last) begin
                    quotient  <= q_nx;
                    remainder <= r_nx;
                end
            end
        end
    end

endmodule
